// File: rtl/ram_bist_initiator.sv
// March-style BIST master for a single-port RAM: writes P(a), reads it back,
// then repeats with ~P(a), recording the mismatch count and the first failure.
module ram_bist_initiator #(
   parameter int                ADDR_W = 10,
   parameter int                DATA_W = 8,
   parameter int                DEPTH  = 1024,
   parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_cs,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+1:0] err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              fail_phase,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_got,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W+1:0]   err_q, err_d;
   logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
   logic                fail_phase_q, fail_phase_d;
   logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;
   logic [DATA_W-1:0]   fail_got_q, fail_got_d;
   logic                pass_q, pass_d;

   logic                is_wr, is_rd, phase1, last;
   logic [DATA_W-1:0]   pat;

   // Moore decode: everything below depends only on state_q and addr_q.
   always_comb begin
      is_wr  = (state_q == S_WR0) || (state_q == S_WR1);
      is_rd  = (state_q == S_RD0) || (state_q == S_RD1);
      phase1 = (state_q == S_WR1) || (state_q == S_RD1);
      last   = (addr_q == ADDR_W'(DEPTH - 1));
      pat    = (addr_q[DATA_W-1:0] ^ SEED) ^ {DATA_W{phase1}};
      mem_cs    = is_wr || is_rd;
      mem_wr    = is_wr;
      mem_addr  = (is_wr || is_rd) ? addr_q : '0;
      mem_wdata = is_wr ? pat : '0;
      busy      = is_wr || is_rd;
      done      = (state_q == S_DONE);
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      err_d        = err_q;
      fail_addr_d  = fail_addr_q;
      fail_phase_d = fail_phase_q;
      fail_exp_d   = fail_exp_q;
      fail_got_d   = fail_got_q;
      pass_d       = pass_q;

      if (is_wr || is_rd) begin
         addr_d = last ? '0 : addr_q + ADDR_W'(1);
      end

      // A zero count means no mismatch yet this run, so it doubles as the first-fail flag.
      if (is_rd && (mem_rdata != pat)) begin
         if (err_q != '1) err_d = err_q + (ADDR_W+2)'(1);
         if (err_q == '0) begin
            fail_addr_d  = addr_q;
            fail_phase_d = phase1;
            fail_exp_d   = pat;
            fail_got_d   = mem_rdata;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_WR0;
               addr_d       = '0;
               err_d        = '0;
               fail_addr_d  = '0;
               fail_phase_d = 1'b0;
               fail_exp_d   = '0;
               fail_got_d   = '0;
               pass_d       = 1'b0;
            end
         end
         S_WR0:   if (last) state_d = S_RD0;
         S_RD0:   if (last) state_d = S_WR1;
         S_WR1:   if (last) state_d = S_RD1;
         S_RD1: begin
            if (last) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         err_q        <= '0;
         fail_addr_q  <= '0;
         fail_phase_q <= 1'b0;
         fail_exp_q   <= '0;
         fail_got_q   <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         err_q        <= err_d;
         fail_addr_q  <= fail_addr_d;
         fail_phase_q <= fail_phase_d;
         fail_exp_q   <= fail_exp_d;
         fail_got_q   <= fail_got_d;
         pass_q       <= pass_d;
      end
   end

   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_addr  = fail_addr_q;
   assign fail_phase = fail_phase_q;
   assign fail_exp   = fail_exp_q;
   assign fail_got   = fail_got_q;
   assign dbg_state  = state_q;

endmodule
